i2s_audio_tx: RTL and testbench
===============================

// Module: i2s_audio_tx
// PURPOSE
// - Downstream audio stage of the MP3 player: takes decoded 16-bit stereo PCM frames from the
//   SoC/decoder and serialises them to the SGTL5000 codec as I2S master (codec in slave mode).
// - Generates BCLK/LRCLK phase-locked to the 12.5 MHz codec MCLK (50 MHz / 4) on the Arduino header.
// - Buffers frames in a small FIFO. Output is silence plus an underrun count when starved.
// PARAMETERS
// - FIFO_DEPTH  16  stereo frames buffered; power of 2, >= 2
// - DATA_W      16  PCM bits per channel; fixed at 16, elaborate-time check
// PORTS
// - clk_clk          in   1   50 MHz system clock (MAX10_CLK1_50)
// - reset_reset_n    in   1   asynchronous, active-low reset
// - enable           in   1   1 = run I2S frame timing; 0 = hold serial outputs idle
// - s_data           in   32  {left[15:0], right[15:0]}, two's complement
// - s_valid          in   1   s_data valid
// - s_ready          out  1   FIFO can accept; transfer when s_valid & s_ready at posedge
// - i2s_bclk         out  1   bit clock = clk/16 (3.125 MHz)
// - i2s_lrclk        out  1   word select = clk/1024 (48.828 kHz); 0 = left, 1 = right
// - i2s_dout         out  1   serial data to codec DIN
// - fifo_level       out  $clog2(FIFO_DEPTH)+1  frames currently held
// - underrun         out  1   one-cycle pulse when a frame boundary finds the FIFO empty
// - underrun_cnt     out  16  saturating count of underrun pulses
// BEHAVIOUR
// - Reset: all outputs 0 except s_ready = 1. FIFO empty, fc = 0, shadow frame = 0.
// - Frame counter fc[9:0] increments every clk while enable = 1 and wraps 1023 -> 0.
//   enable = 0 forces fc = 0 and clears the shadow frame on the next clk.
// - Slot bit n = fc[8:4] (0..31). Channel = fc[9]. BCLK level = fc[3] (low on first 8 clks of each bit).
// - I2S timing: the MSB is driven in slot bit 1, one BCLK after the LRCLK edge.
//   Slot n in 1..16 drives channel bit [16-n]. Slots 0 and 17..31 drive 0.
// - i2s_bclk, i2s_lrclk, i2s_dout are registered functions of fc.
//   All three lag fc by exactly 1 clk, so they stay mutually aligned.
//   dout changes only on BCLK falling edges; the codec samples on rising edges.
//   enable = 0 drives all three to 0.
// - Frame load at fc == 1023 with enable = 1:
//   - FIFO non-empty: pop the head into the shadow {L,R} used by the following frame.
//   - FIFO empty: load 0, pulse underrun, increment underrun_cnt; saturates at 16'hFFFF.
// - Latency: a frame pushed into an empty FIFO while running is serialised starting at the next fc wrap.
//   Its left MSB appears on i2s_dout 1 + 16 clks after the wrap.
// - FIFO: s_ready = !full, registered from level.
//   - Push and pop in the same cycle while full: pop occurs; push is not accepted because s_ready was 0.
//   - Push and pop in the same cycle while empty: underrun is declared; the pushed frame is stored.
//   - Push and pop in the same cycle otherwise: fifo_level is unchanged.
// - Pushes are accepted regardless of enable. Reset mid-frame aborts immediately to reset values.
// - fifo_level and underrun_cnt update 1 clk after the causing edge.
// STRUCTURE
// - Shared package mp3_audio_pkg:
//   - typedef stereo_frame_t {logic [15:0] l, r;}
//   - localparams BCLK_DIV = 16, FRAME_CLKS = 1024, SLOT_BITS = 32
// - Sub-module sample_fifo: synchronous FIFO (FIFO_DEPTH x 32, level/full/empty, async active-low reset).
// - Top: frame counter, shadow register, shift/select logic, underrun counter.
// TESTING
// - Reset: check the reset values listed in BEHAVIOUR.
//   -> all outputs 0 except s_ready = 1; fifo_level = 0; underrun_cnt = 0.
// - Push 32'hA5A5_3C3C, then enable = 1. Clock timing:
//   -> BCLK period 16 clk; LRCLK period 1024 clk.
//   Serial data in the next frame:
//   -> left slots 1..16 = 1010010110100101; right slots 1..16 = 0011110000111100; all other slots 0.
// - With enable = 0, push 17 frames back-to-back:
//   -> s_ready = 0 after the 16th; the 17th is not accepted; fifo_level = 16.
// - enable = 1 with the FIFO empty for 3 frames:
//   -> i2s_dout = 0; underrun pulses 3 times, once per fc wrap; underrun_cnt = 3.
//   With the counter forced near 16'hFFFF: -> underrun_cnt saturates at 16'hFFFF.
// - Push while empty, timed so the push lands on the fc == 1023 edge:
//   -> underrun pulses; the frame is stored and played in the following frame.
// - Assert reset_reset_n low mid-frame (fc = 300) with 4 frames queued:
//   -> outputs go to reset values immediately; fifo_level = 0; after release, BCLK restarts from fc = 0.

Source files
------------

// File: rtl/mp3_audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mp3_audio_pkg
//  Description : Shared types, frame-timing constants and the I2S slot-bit
//                selection helper for the MP3 player audio output path.
//  Revision    : 1.0 - initial release
// ============================================================================
package mp3_audio_pkg;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } stereo_frame_t;

    localparam int BCLK_DIV   = 16;
    localparam int FRAME_CLKS = 1024;
    localparam int SLOT_BITS  = 32;

    // Serial bit for one slot of one channel. The MSB sits in slot 1, one
    // BCLK after the LRCLK edge; slots 0 and 17..31 are padding zeros.
    function automatic logic slot_bit(input stereo_frame_t frame,
                                      input logic          chan,
                                      input logic [4:0]    slot);
        logic [15:0] word;
        logic [4:0]  idx;
        word = chan ? frame.r : frame.l;
        idx  = 5'd16 - slot;
        if (slot >= 5'd1 && slot <= 5'd16) begin
            return word[idx[3:0]];
        end
        return 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_audio_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sample_fifo
//  Description : Synchronous FIFO for stereo PCM frames with level, full and
//                empty flags. Push is ignored when full, pop when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_level == c_lvl_w'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Storage array; no reset needed, contents are only read when valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_audio_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_audio_tx
//  Description : I2S master transmitter for the SGTL5000 codec. Buffers
//                16-bit stereo PCM frames, derives BCLK/LRCLK from a 10-bit
//                frame counter and shifts data MSB first, one BCLK after the
//                LRCLK edge. Starvation plays silence and counts underruns.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_audio_tx
    import mp3_audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 16
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          enable,
    input  logic [31:0]                   s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_dout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic [15:0]                   underrun_cnt
);

    localparam int c_fc_w  = $clog2(FRAME_CLKS);
    localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;

    generate
        if (DATA_W != 16) begin : g_data_w_check
            $error("i2s_audio_tx: DATA_W must be 16");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
            $error("i2s_audio_tx: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [c_fc_w-1:0]  r_fc;
    stereo_frame_t      r_shadow;
    logic               r_bclk;
    logic               r_lrclk;
    logic               r_dout;
    logic               r_underrun;
    logic [15:0]        r_underrun_cnt;

    logic               w_load;
    logic               w_full;
    logic               w_empty;
    logic [31:0]        w_rd_data;
    logic [c_lvl_w-1:0] w_level;

    // Frame boundary: the last clock of the 1024-clock I2S frame.
    assign w_load = enable & (r_fc == c_fc_w'(FRAME_CLKS - 1));

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .i_push    (s_valid),
        .i_wr_data (s_data),
        .i_pop     (w_load),
        .o_rd_data (w_rd_data),
        .o_level   (w_level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign s_ready      = ~w_full;
    assign fifo_level   = w_level;
    assign i2s_bclk     = r_bclk;
    assign i2s_lrclk    = r_lrclk;
    assign i2s_dout     = r_dout;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_underrun_cnt;

    // Free-running frame counter while enabled; parked at 0 when disabled.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_fc <= '0;
        end else if (!enable) begin
            r_fc <= '0;
        end else begin
            r_fc <= r_fc + c_fc_w'(1);
        end
    end

    // Shadow frame: loaded from the FIFO head at each boundary, silence on starvation.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_shadow <= '0;
        end else if (!enable) begin
            r_shadow <= '0;
        end else if (w_load) begin
            r_shadow <= w_empty ? stereo_frame_t'('0) : stereo_frame_t'(w_rd_data);
        end
    end

    // Underrun pulse and saturating counter.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_underrun <= w_load & w_empty;
            if (w_load && w_empty && r_underrun_cnt != 16'hFFFF) begin
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end
        end
    end

    // Serial outputs: registered decode of fc, so all three lag fc by one clock
    // and data only moves while BCLK is low.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_bclk  <= 1'b0;
            r_lrclk <= 1'b0;
            r_dout  <= 1'b0;
        end else if (!enable) begin
            r_bclk  <= 1'b0;
            r_lrclk <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            r_bclk  <= r_fc[3];
            r_lrclk <= r_fc[9];
            r_dout  <= slot_bit(r_shadow, r_fc[9], r_fc[8:4]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_audio_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_audio_tx
//  Description : Self-checking bench for i2s_audio_tx with a frame-level
//                behavioural model and directed plus randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_audio_tx;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_clk       = 1'b0;
    logic          reset_reset_n = 1'b0;
    logic          enable        = 1'b0;
    logic [31:0]   s_data        = '0;
    logic          s_valid       = 1'b0;
    logic          s_ready;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_dout;
    logic [LW-1:0] fifo_level;
    logic          underrun;
    logic [15:0]   underrun_cnt;

    always #10 clk_clk = ~clk_clk;

    i2s_audio_tx #(.FIFO_DEPTH(DEPTH), .DATA_W(16)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .enable        (enable),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrclk     (i2s_lrclk),
        .i2s_dout      (i2s_dout),
        .fifo_level    (fifo_level),
        .underrun      (underrun),
        .underrun_cnt  (underrun_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_fc;
    logic [31:0] m_cur;
    logic [31:0] m_q[$];
    int          m_cnt;
    bit          e_bclk, e_lr, e_dout, e_ur;

    // Serial bit at frame position fc: MSB in bit-slot 1 of each half-frame.
    function automatic bit exp_bit(input logic [31:0] fr, input int fc);
        int          slot;
        logic [15:0] w;
        slot = (fc / 16) % 32;
        w    = (fc >= 512) ? fr[15:0] : fr[31:16];
        if (slot >= 1 && slot <= 16) return w[16 - slot];
        return 1'b0;
    endfunction

    always @(posedge clk_clk or negedge reset_reset_n) begin
        bit was_full, was_empty;
        if (!reset_reset_n) begin
            m_fc = 0; m_cur = '0; m_q.delete(); m_cnt = 0;
            e_bclk = 0; e_lr = 0; e_dout = 0; e_ur = 0;
        end else begin
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            if (enable) begin
                e_bclk = (m_fc % 16) >= 8;
                e_lr   = m_fc >= 512;
                e_dout = exp_bit(m_cur, m_fc);
            end else begin
                e_bclk = 0; e_lr = 0; e_dout = 0;
            end
            e_ur = 0;
            if (enable && m_fc == 1023) begin
                if (!was_empty) m_cur = m_q.pop_front();
                else begin
                    m_cur = '0;
                    e_ur  = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            if (s_valid && !was_full) m_q.push_back(s_data);
            if (!enable) begin m_fc = 0; m_cur = '0; end
            else m_fc = (m_fc + 1) % 1024;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk_clk) begin
        check("bclk",   32'(i2s_bclk),     32'(e_bclk));
        check("lrclk",  32'(i2s_lrclk),    32'(e_lr));
        check("dout",   32'(i2s_dout),     32'(e_dout));
        check("ready",  32'(s_ready),      32'(m_q.size() < DEPTH));
        check("level",  32'(fifo_level),   32'(m_q.size()));
        check("urun",   32'(underrun),     32'(e_ur));
        check("urcnt",  32'(underrun_cnt), 32'(m_cnt));
    end

    // Period measurement of the serial clocks, in system clocks.
    int  b_per = 0, l_per = 0;
    time b_t = 0, l_t = 0;
    bit  p_b = 0, p_l = 0;
    always @(negedge clk_clk) begin
        if (i2s_bclk && !p_b) begin b_per = int'(($time - b_t) / 20); b_t = $time; end
        if (i2s_lrclk && !p_l) begin l_per = int'(($time - l_t) / 20); l_t = $time; end
        p_b = i2s_bclk;
        p_l = i2s_lrclk;
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic do_reset();
        #2 reset_reset_n = 1'b0;
        step(2);
        #2 reset_reset_n = 1'b1;
        step(1);
    endtask

    // Sample dout mid-bit for each slot of the frame starting at the next edge.
    task automatic capture_frame(output logic [15:0] l, output logic [15:0] r, output int other);
        l = '0; r = '0; other = 0;
        for (int c = 0; c < 1024; c++) begin
            @(negedge clk_clk);
            if (c % 16 == 8) begin
                int slot;
                slot = (c / 16) % 32;
                if (slot >= 1 && slot <= 16) begin
                    if (c >= 512) r[16 - slot] = i2s_dout;
                    else          l[16 - slot] = i2s_dout;
                end else if (i2s_dout) begin
                    other++;
                end
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bclk"},  32'(i2s_bclk),     32'd0);
        check({tag, "_lrclk"}, 32'(i2s_lrclk),    32'd0);
        check({tag, "_dout"},  32'(i2s_dout),     32'd0);
        check({tag, "_ready"}, 32'(s_ready),      32'd1);
        check({tag, "_level"}, 32'(fifo_level),   32'd0);
        check({tag, "_urun"},  32'(underrun),     32'd0);
        check({tag, "_urcnt"}, 32'(underrun_cnt), 32'd0);
    endtask

    // ---------------- directed and random tests ----------------
    initial begin
        logic [15:0] cl, cr;
        int          oth, pulses, ones, n;
        bit          found;

        // Reset values
        step(3);
        check_reset_values("rst");
        #2 reset_reset_n = 1'b1;
        step(2);

        // Known frame: clock periods and serial bit pattern
        s_data = 32'hA5A5_3C3C; s_valid = 1'b1;
        step(1);
        s_valid = 1'b0;
        check("push1_level", 32'(fifo_level), 32'd1);
        enable = 1'b1;
        step(1024);
        capture_frame(cl, cr, oth);
        check("left_bits",   32'(cl),  32'h0000_A5A5);
        check("right_bits",  32'(cr),  32'h0000_3C3C);
        check("pad_bits",    32'(oth), 32'd0);
        check("bclk_period", 32'(b_per), 32'd16);
        check("lrclk_period", 32'(l_per), 32'd1024);
        enable = 1'b0;
        step(2);

        // Starved playback for three frames
        do_reset();
        enable = 1'b1;
        pulses = 0; ones = 0;
        for (int i = 0; i < 3076; i++) begin
            step(1);
            if (underrun) pulses++;
            if (i2s_dout) ones++;
        end
        check("urun_pulses", 32'(pulses), 32'd3);
        check("urun_count3", 32'(underrun_cnt), 32'd3);
        check("starve_dout", 32'(ones), 32'd0);

        // Saturation of the underrun counter
        #2;
        force dut.r_underrun_cnt = 16'hFFFE;
        m_cnt = 65534;
        #1 release dut.r_underrun_cnt;
        step(3 * 1024);
        check("urun_sat", 32'(underrun_cnt), 32'h0000_FFFF);
        enable = 1'b0;
        step(2);

        // Fill the FIFO with enable low, one frame too many
        do_reset();
        for (int i = 0; i < 17; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            step(1);
            if (i == 15) begin
                check("full_ready", 32'(s_ready),    32'd0);
                check("full_level", 32'(fifo_level), 32'd16);
            end
        end
        s_valid = 1'b0;
        step(1);
        check("full_level17", 32'(fifo_level), 32'd16);

        // Push landing on the frame-boundary edge with an empty FIFO
        do_reset();
        enable = 1'b1;
        found  = 0;
        for (int i = 0; i < 2100 && !found; i++) begin
            if (m_fc == 1023) found = 1;
            else step(1);
        end
        check("fc1023_wait", 32'(found), 32'd1);
        s_valid = 1'b1; s_data = 32'h8001_7FFE;
        step(1);
        s_valid = 1'b0;
        check("edge_urun",  32'(underrun),   32'd1);
        check("edge_level", 32'(fifo_level), 32'd1);
        step(1024);
        capture_frame(cl, cr, oth);
        check("edge_left",  32'(cl), 32'h0000_8001);
        check("edge_right", 32'(cr), 32'h0000_7FFE);

        // Randomized traffic with occasional enable toggling
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 12000; i++) begin
            s_valid = ($urandom_range(0, 499) == 0);
            s_data  = $urandom;
            if ($urandom_range(0, 2999) == 0) enable = ~enable;
            step(1);
        end
        s_valid = 1'b0;
        enable  = 1'b0;
        step(2);

        // Reset mid-frame with frames queued
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = $urandom;
            step(1);
        end
        s_valid = 1'b0;
        enable  = 1'b1;
        step(300);
        #2 reset_reset_n = 1'b0;
        #1 check_reset_values("midrst");
        step(2);
        #2 reset_reset_n = 1'b1;
        n = 0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(1);
            n++;
            if (i2s_bclk) found = 1;
        end
        check("restart_bclk", 32'(n), 32'd9);
        step(1100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
